// File: rtl/mebx_led_pio_pkg.sv
// Shared constants for the LED PIO: register word addresses and blink period width.
package mebx_led_pio_pkg;

    localparam int unsigned PERIOD_W = 24;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_OUTSET   = 3'd3;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd4;
    localparam logic [2:0] ADDR_STATUS   = 3'd5;

endpackage

// File: rtl/mebx_led_pio_blink_timer.sv
// Free-running blink counter; phase toggles each time the counter wraps at period-1.
module mebx_led_pio_blink_timer
    import mebx_led_pio_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                load,
    output logic [PERIOD_W-1:0] count,
    output logic                phase
);

    // A period load takes priority over any wrap due on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            phase <= 1'b1;
        end else if (load || period == '0) begin
            count <= '0;
            phase <= 1'b1;
        end else if (count == period - 24'd1) begin
            count <= '0;
            phase <= ~phase;
        end else begin
            count <= count + 24'd1;
        end
    end

endmodule

// File: rtl/mebx_led_pio.sv
// Avalon-MM LED PIO: data register with set/clear aliases and a per-bit blink mask.
module mebx_led_pio
    import mebx_led_pio_pkg::*;
#(
    parameter int unsigned     WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]    data;
    logic [WIDTH-1:0]    blink_en;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] count;
    logic                phase;
    logic                wr;
    logic                period_load;
    logic [31:0]         rd_next;

    assign wr          = chipselect && !write_n;
    assign period_load = wr && (address == ADDR_PERIOD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data     <= RESET_VALUE;
            blink_en <= '0;
            period   <= '0;
        end else if (wr) begin
            case (address)
                ADDR_DATA:     data     <= writedata[WIDTH-1:0];
                ADDR_BLINK_EN: blink_en <= writedata[WIDTH-1:0];
                ADDR_PERIOD:   period   <= writedata[PERIOD_W-1:0];
                ADDR_OUTSET:   data     <= data | writedata[WIDTH-1:0];
                ADDR_OUTCLEAR: data     <= data & ~writedata[WIDTH-1:0];
                default: ;
            endcase
        end
    end

    mebx_led_pio_blink_timer u_blink_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period),
        .load    (period_load),
        .count   (count),
        .phase   (phase)
    );

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:     rd_next = 32'(data);
            ADDR_BLINK_EN: rd_next = 32'(blink_en);
            ADDR_PERIOD:   rd_next = 32'(period);
            ADDR_STATUS:   rd_next = 32'({count, phase});
            default:       rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_next;
    end

    assign out_port = data & ~(blink_en & {WIDTH{~phase}});

endmodule

// File: doc/mebx_led_pio.md
MEBX_LED_PIO -- requirements
Module: mebx_led_pio

Interface
REQ-001 Parameter WIDTH, default 8: number of output port bits, legal range 1..32.
REQ-002 Parameter RESET_VALUE, default 0: DATA register value after reset, WIDTH bits.
REQ-003 clk  input  1: single clock, all state on rising edge.
REQ-004 reset_n  input  1: reset, asynchronous, active-low.
REQ-005 address  input  3: Avalon-MM word address.
REQ-006 chipselect  input  1: slave select; a write is accepted only when chipselect=1 and write_n=0.
REQ-007 write_n  input  1: active-low write strobe.
REQ-008 writedata  input  32: write data; bits above the register width are ignored.
REQ-009 readdata  output  32: registered read data; unused upper bits are 0.
REQ-010 out_port  output  WIDTH: driven output pins (LEDs).

Function
REQ-011 Register map: 0 DATA (R/W), 1 BLINK_EN (R/W mask), 2 PERIOD (R/W, 24 bits), 3 OUTSET (W), 4 OUTCLEAR (W), 5 STATUS (R).
REQ-012 Fixed wait states, no waitrequest; every accepted write takes effect on the clk edge where it is sampled.
REQ-013 readdata SHALL update every clk edge with the mux of address, giving 1-cycle read latency, independent of chipselect.
REQ-014 OUTSET write: DATA <= DATA | writedata[WIDTH-1:0]; OUTCLEAR write: DATA <= DATA & ~writedata[WIDTH-1:0].
REQ-015 OUTSET, OUTCLEAR and addresses 6..7 read 0; writes to 5..7 are ignored.
REQ-016 STATUS read: bit0 = blink phase, bits 24:1 = current counter value.
REQ-017 Blink engine: 24-bit counter and 1-bit phase.
REQ-018 If PERIOD = 0: counter holds 0 and phase holds 1.
REQ-019 If PERIOD > 0: counter increments each cycle. When counter = PERIOD-1, the counter wraps to 0 and phase toggles in the same edge.
REQ-020 A write to PERIOD loads the new value, clears the counter to 0 and sets phase to 1 in the same edge. It overrides any wrap or toggle due that cycle.
REQ-021 out_port = DATA & ~(BLINK_EN & {WIDTH{~phase}}). This is combinational from registers, so a register write is visible on out_port right after the accepting edge.
REQ-022 A DATA or BLINK_EN write does not disturb the counter or the phase.

Reset
REQ-023 While reset_n=0: DATA=RESET_VALUE, BLINK_EN=0, PERIOD=0, counter=0, phase=1, readdata=0.
REQ-024 Consequently out_port=RESET_VALUE throughout reset.
REQ-025 Reset asserted mid-blink returns all state to REQ-023 values at once, without waiting for a clk edge.
REQ-026 Deassertion is synchronised externally; the first edge after deassertion behaves as a normal cycle.

Structure
REQ-027 A shared package holds the register address constants (ADDR_DATA..ADDR_STATUS) and the PERIOD width constant (24).
REQ-028 One sub-module, mebx_led_pio_blink_timer, contains the counter, phase, PERIOD-load clear and wrap logic.
REQ-029 The top level contains the register file, write decode, read mux and output logic.

Verification
REQ-030 Reset with RESET_VALUE=0x5A -> out_port=0x5A, readdata=0; read addr 5 -> 0x00000001.
REQ-031 Write DATA=0xF0, OUTSET=0x03, OUTCLEAR=0x30 -> out_port 0xF0, 0xF3, 0xC3 after each respective edge; read addr 0 -> 0x000000C3 one cycle after the address is presented.
REQ-032 Write DATA=0xFF, BLINK_EN=0x0F, PERIOD=4 -> out_port toggles 0xFF/0xF0 every 4 cycles; STATUS counter sequence 0,1,2,3,0.
REQ-033 Write PERIOD=4 on the exact cycle counter=3 -> counter=0, phase=1, no toggle; the next toggle occurs 4 cycles later.
REQ-034 Write with chipselect=0, or to address 6 -> no register change; reads of 3, 4, 6 and 7 return 0.
REQ-035 Assert reset_n while phase=0 mid-blink -> out_port=RESET_VALUE immediately; PERIOD reads 0 after release.
